// File: rtl/adpll_cfg_seq.sv
// ADPLL bring-up sequencer: programs the control write list, polls ADPLL_LOCK,
// then captures ADPLL_SAT. One outstanding bus transaction at a time.
module adpll_cfg_seq #(
   parameter int unsigned POLL_GAP    = 64,
   parameter int unsigned LOCK_POLLS  = 1024,
   parameter int unsigned ACK_TIMEOUT = 4,
   parameter int unsigned FCW_W       = 28,
   parameter int unsigned ADDR_W      = 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic              i_abort,
   input  logic [FCW_W-1:0]  i_fcw,
   input  logic [1:0]        i_mode,
   output logic              o_valid,
   output logic [ADDR_W-1:0] o_address,
   output logic [31:0]       o_wdata,
   output logic              o_wstrb,
   input  logic [31:0]       i_rdata,
   input  logic              i_ready,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_locked,
   output logic              o_sat,
   output logic              o_err_timeout,
   output logic              o_err_bus
);
   localparam int unsigned GW = $clog2(POLL_GAP + 1);
   localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
   localparam int unsigned PW = $clog2(LOCK_POLLS + 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(POLL_GAP - 1);
   localparam logic [TW-1:0] ACK_LAST  = TW'(ACK_TIMEOUT - 1);
   localparam logic [PW-1:0] POLL_LAST = PW'(LOCK_POLLS);

   localparam logic [ADDR_W-1:0] A_SOFT_RST  = ADDR_W'(8'h00);
   localparam logic [ADDR_W-1:0] A_FCW       = ADDR_W'(8'h04);
   localparam logic [ADDR_W-1:0] A_MODE      = ADDR_W'(8'h08);
   localparam logic [ADDR_W-1:0] A_DCO_PD    = ADDR_W'(8'h0C);
   localparam logic [ADDR_W-1:0] A_TDC_PD    = ADDR_W'(8'h10);
   localparam logic [ADDR_W-1:0] A_TDC_INJ   = ADDR_W'(8'h14);
   localparam logic [ADDR_W-1:0] A_EN        = ADDR_W'(8'h18);
   localparam logic [ADDR_W-1:0] A_LOCK      = ADDR_W'(8'h1C);
   localparam logic [ADDR_W-1:0] A_SAT       = ADDR_W'(8'h20);

   typedef enum logic [3:0] {
      StIdle, StWrReq, StWrAck, StGap, StRdReq, StRdAck,
      StSatReq, StSatAck, StAbReq, StAbAck, StFin
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [2:0]        r_idx, w_idx_nxt;
   logic [GW-1:0]     r_gap_cnt, w_gap_nxt;
   logic [TW-1:0]     r_ack_cnt, w_ack_nxt;
   logic [PW-1:0]     r_poll_cnt, w_poll_nxt;
   logic [FCW_W-1:0]  r_fcw, w_fcw_nxt;
   logic [1:0]        r_mode, w_mode_nxt;
   logic              r_abort, w_abort_nxt;
   logic              r_done, w_done_nxt;
   logic              r_locked, w_locked_nxt;
   logic              r_sat, w_sat_nxt;
   logic              r_err_timeout, w_err_to_nxt;
   logic              r_err_bus, w_err_bus_nxt;
   logic              w_abort_req, w_in_ack, w_unused_rdata;
   logic [ADDR_W-1:0] w_wr_addr;
   logic [31:0]       w_wr_data;

   assign w_abort_req    = r_abort | i_abort;
   assign w_in_ack       = r_state inside {StWrAck, StRdAck, StSatAck, StAbAck};
   assign w_unused_rdata = ^i_rdata[31:1];

   always_comb begin
      w_wr_addr = A_EN;
      w_wr_data = 32'd1;
      case (r_idx)
         3'd0: begin w_wr_addr = A_SOFT_RST; w_wr_data = 32'd1;        end
         3'd1: begin w_wr_addr = A_FCW;      w_wr_data = 32'(r_fcw);   end
         3'd2: begin w_wr_addr = A_MODE;     w_wr_data = 32'(r_mode);  end
         3'd3: begin w_wr_addr = A_DCO_PD;   w_wr_data = 32'd0;        end
         3'd4: begin w_wr_addr = A_TDC_PD;   w_wr_data = 32'd0;        end
         3'd5: begin w_wr_addr = A_TDC_INJ;  w_wr_data = 32'd0;        end
         default: ;
      endcase
   end

   // Address/data/strobe stay put through the ACK state until ready.
   always_comb begin
      o_address = '0;
      o_wdata   = '0;
      o_wstrb   = 1'b0;
      case (r_state)
         StWrReq, StWrAck: begin
            o_address = w_wr_addr;
            o_wdata   = w_wr_data;
            o_wstrb   = 1'b1;
         end
         StRdReq, StRdAck:   o_address = A_LOCK;
         StSatReq, StSatAck: o_address = A_SAT;
         StAbReq, StAbAck: begin
            o_address = A_EN;
            o_wstrb   = 1'b1;
         end
         default: ;
      endcase
      o_valid = r_state inside {StWrReq, StRdReq, StSatReq, StAbReq};
      o_busy  = !(r_state inside {StIdle, StFin});
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_idx_nxt     = r_idx;
      w_gap_nxt     = r_gap_cnt;
      w_ack_nxt     = r_ack_cnt;
      w_poll_nxt    = r_poll_cnt;
      w_fcw_nxt     = r_fcw;
      w_mode_nxt    = r_mode;
      w_abort_nxt   = (r_state != StIdle) && w_abort_req;
      w_done_nxt    = r_done;
      w_locked_nxt  = r_locked;
      w_sat_nxt     = r_sat;
      w_err_to_nxt  = r_err_timeout;
      w_err_bus_nxt = r_err_bus;
      case (r_state)
         StIdle: if (i_start) begin
            w_state_nxt   = StWrReq;
            w_idx_nxt     = 3'd0;
            w_poll_nxt    = '0;
            w_fcw_nxt     = i_fcw;
            w_mode_nxt    = i_mode;
            w_done_nxt    = 1'b0;
            w_locked_nxt  = 1'b0;
            w_sat_nxt     = 1'b0;
            w_err_to_nxt  = 1'b0;
            w_err_bus_nxt = 1'b0;
         end
         StWrReq:  begin w_ack_nxt = TW'(1); w_state_nxt = StWrAck;  end
         StRdReq:  begin w_ack_nxt = TW'(1); w_state_nxt = StRdAck;  end
         StSatReq: begin w_ack_nxt = TW'(1); w_state_nxt = StSatAck; end
         StAbReq:  begin w_ack_nxt = TW'(1); w_state_nxt = StAbAck;  end
         StWrAck: if (i_ready) begin
            if (w_abort_req) begin
               w_state_nxt = StAbReq;
            end else if (r_idx == 3'd6) begin
               w_state_nxt = StGap;
               w_gap_nxt   = '0;
            end else begin
               w_idx_nxt   = r_idx + 3'd1;
               w_state_nxt = StWrReq;
            end
         end
         StGap: begin
            if (w_abort_req)                w_state_nxt = StAbReq;
            else if (r_gap_cnt == GAP_LAST) w_state_nxt = StRdReq;
            else                            w_gap_nxt   = r_gap_cnt + 1'b1;
         end
         StRdAck: if (i_ready) begin
            w_locked_nxt = i_rdata[0];
            if (w_abort_req) begin
               w_state_nxt = StAbReq;
            end else if (i_rdata[0]) begin
               w_state_nxt = StSatReq;
            end else begin
               w_poll_nxt = r_poll_cnt + 1'b1;
               if (r_poll_cnt + 1'b1 == POLL_LAST) begin
                  w_err_to_nxt = 1'b1;
                  w_state_nxt  = StFin;
               end else begin
                  w_state_nxt = StGap;
                  w_gap_nxt   = '0;
               end
            end
         end
         StSatAck: if (i_ready) begin
            w_sat_nxt   = i_rdata[0];
            w_state_nxt = w_abort_req ? StAbReq : StFin;
         end
         StAbAck: if (i_ready) begin
            w_locked_nxt = 1'b0;
            w_state_nxt  = StFin;
         end
         StFin:   w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
      // Missing acknowledge: the flag shows on the ACK_TIMEOUT-th cycle after valid.
      if (w_in_ack && !i_ready) begin
         if (r_ack_cnt >= ACK_LAST) begin
            w_err_bus_nxt = 1'b1;
            w_done_nxt    = 1'b1;
            w_state_nxt   = StIdle;
         end else begin
            w_ack_nxt = r_ack_cnt + 1'b1;
         end
      end
      if (w_state_nxt == StFin) w_done_nxt = 1'b1;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state       <= StIdle;
         r_idx         <= '0;
         r_gap_cnt     <= '0;
         r_ack_cnt     <= '0;
         r_poll_cnt    <= '0;
         r_fcw         <= '0;
         r_mode        <= '0;
         r_abort       <= 1'b0;
         r_done        <= 1'b0;
         r_locked      <= 1'b0;
         r_sat         <= 1'b0;
         r_err_timeout <= 1'b0;
         r_err_bus     <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_idx         <= w_idx_nxt;
         r_gap_cnt     <= w_gap_nxt;
         r_ack_cnt     <= w_ack_nxt;
         r_poll_cnt    <= w_poll_nxt;
         r_fcw         <= w_fcw_nxt;
         r_mode        <= w_mode_nxt;
         r_abort       <= w_abort_nxt;
         r_done        <= w_done_nxt;
         r_locked      <= w_locked_nxt;
         r_sat         <= w_sat_nxt;
         r_err_timeout <= w_err_to_nxt;
         r_err_bus     <= w_err_bus_nxt;
      end
   end

   assign o_done        = r_done;
   assign o_locked      = r_locked;
   assign o_sat         = r_sat;
   assign o_err_timeout = r_err_timeout;
   assign o_err_bus     = r_err_bus;

endmodule

// File: tb/tb_adpll_cfg_seq.sv
// Bench for adpll_cfg_seq: a timeline model predicts every bus request and the
// busy/done window; a scripted slave answers reads.
module tb_adpll_cfg_seq;
   localparam int G = 8;
   localparam int LP = 4;
   localparam logic [7:0] A_SRST = 8'h00, A_FCW = 8'h04, A_MODE = 8'h08, A_DCO = 8'h0C;
   localparam logic [7:0] A_TDC = 8'h10, A_INJ = 8'h14, A_EN = 8'h18, A_LOCK = 8'h1C;
   localparam logic [7:0] A_SAT = 8'h20;

   typedef struct {
      int          cyc;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic        wstrb;
   } txn_t;

   logic        clk = 1'b0, rst = 1'b1;
   logic        i_start = 1'b0, i_abort = 1'b0, i_ready = 1'b0;
   logic [27:0] i_fcw = '0;
   logic [1:0]  i_mode = '0;
   logic [31:0] i_rdata = '0;
   logic        o_valid, o_wstrb, o_busy, o_done, o_locked, o_sat, o_err_timeout, o_err_bus;
   logic [7:0]  o_address;
   logic [31:0] o_wdata;

   int   cyc = 0, s = 0, s_end = 0, r0 = 0, lock_reads = 0;
   int   n_tests = 0, n_fail = 0;
   bit   mon_on = 1'b0, slave_en = 1'b1, sat_val = 1'b1;
   bit   ack_pend = 1'b0, prev_valid = 1'b0;
   logic [7:0] ack_addr = '0, prev_addr = '0;
   bit   lock_q[$];
   txn_t exp_q[$];
   txn_t obs_q[$];

   adpll_cfg_seq #(
      .POLL_GAP(G), .LOCK_POLLS(LP), .ACK_TIMEOUT(4), .FCW_W(28), .ADDR_W(8)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_abort(i_abort), .i_fcw(i_fcw),
      .i_mode(i_mode), .o_valid(o_valid), .o_address(o_address), .o_wdata(o_wdata),
      .o_wstrb(o_wstrb), .i_rdata(i_rdata), .i_ready(i_ready), .o_busy(o_busy),
      .o_done(o_done), .o_locked(o_locked), .o_sat(o_sat),
      .o_err_timeout(o_err_timeout), .o_err_bus(o_err_bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Slave: acknowledges one cycle after each valid; upper rdata bits are noise.
   always @(negedge clk)
      if (!rst && o_valid && slave_en) begin
         ack_pend = 1'b1;
         ack_addr = o_address;
      end
   always @(posedge clk) begin
      #1;
      i_ready = 1'b0;
      i_rdata = '0;
      if (rst) ack_pend = 1'b0;
      else if (ack_pend) begin
         ack_pend = 1'b0;
         i_ready  = 1'b1;
         i_rdata  = {31'h2B3C4D5E, 1'b0};
         if (ack_addr == A_LOCK) begin
            lock_reads++;
            if (lock_q.size() > 0) i_rdata[0] = lock_q.pop_front();
         end else if (ack_addr == A_SAT) begin
            i_rdata[0] = sat_val;
         end
      end
   end

   // Compare process: every request against the model timeline, every cycle's busy/done.
   always @(negedge clk) begin
      if (!rst) begin
         if (prev_valid) chk("hold_addr", o_address, prev_addr);
         if (o_valid) begin
            obs_q.push_back('{cyc, o_address, o_wdata, o_wstrb});
            if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
            else begin
               txn_t e;
               e = exp_q.pop_front();
               chk("txn_cycle", cyc, e.cyc);
               chk("txn_addr", o_address, e.addr);
               chk("txn_wdata", o_wdata, e.wdata);
               chk("txn_wstrb", o_wstrb, e.wstrb);
            end
         end
         if (mon_on) begin
            chk("busy", o_busy, (cyc > s) && (cyc < s_end));
            chk("done", o_done, cyc >= s_end);
         end
      end
      prev_valid = !rst && o_valid;
      prev_addr  = o_address;
   end

   task automatic wait_cyc(input int c);
      do @(negedge clk); while (cyc < c);
   endtask

   task automatic at_cycle(input int c);
      wait_cyc(c - 1);
      @(posedge clk);
      #1;
   endtask

   task automatic start_pulse(input logic [27:0] f, input logic [1:0] m, input bit ab);
      @(posedge clk);
      #1;
      mon_on = 1'b0;
      s = cyc;
      exp_q.delete();
      obs_q.delete();
      lock_reads = 0;
      i_fcw = f;
      i_mode = m;
      i_start = 1'b1;
      i_abort = ab;
   endtask

   task automatic release_start();
      @(posedge clk);
      #1;
      i_start = 1'b0;
      i_abort = 1'b0;
      mon_on = 1'b1;
   endtask

   // Write k of the list goes out at s+1+2k; first LOCK read after a POLL_GAP idle run.
   task automatic add_writes(input logic [27:0] f, input logic [1:0] m, input int n);
      logic [7:0]  a[7];
      logic [31:0] d[7];
      a = '{A_SRST, A_FCW, A_MODE, A_DCO, A_TDC, A_INJ, A_EN};
      d = '{32'd1, {4'd0, f}, {30'd0, m}, 32'd0, 32'd0, 32'd0, 32'd1};
      for (int k = 0; k < n; k++) exp_q.push_back('{s + 1 + 2 * k, a[k], d[k], 1'b1});
      r0 = s + 15 + G;
   endtask

   task automatic add_reads(input int n);
      for (int j = 0; j < n; j++) exp_q.push_back('{r0 + j * (G + 2), A_LOCK, 32'd0, 1'b0});
   endtask

   initial begin : main
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_valid", o_valid, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_done", o_done, 0);
      chk("rst_locked", o_locked, 0);
      chk("rst_sat", o_sat, 0);
      chk("rst_err_to", o_err_timeout, 0);
      chk("rst_err_bus", o_err_bus, 0);
      chk("rst_addr", o_address, 0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Bring-up with lock on the third poll; a start while busy must be ignored.
      lock_q = '{1'b0, 1'b0, 1'b1};
      start_pulse(28'h2620000, 2'd1, 1'b0);
      add_writes(28'h2620000, 2'd1, 7);
      add_reads(3);
      exp_q.push_back('{r0 + 2 * (G + 2) + 2, A_SAT, 32'd0, 1'b0});
      s_end = r0 + 2 * (G + 2) + 4;
      release_start();
      at_cycle(s + 20);
      i_start = 1'b1;
      i_fcw = 28'hFFFFFFF;
      @(posedge clk);
      #1 i_start = 1'b0;
      wait_cyc(s_end);
      chk("A_done", o_done, 1);
      chk("A_locked", o_locked, 1);
      chk("A_sat", o_sat, 1);
      chk("A_err_to", o_err_timeout, 0);
      chk("A_all_seen", exp_q.size(), 0);
      chk("A_n_txn", obs_q.size(), 11);
      chk("A_fcw_wdata", obs_q[1].wdata, 32'h02620000);
      chk("A_mode_wdata", obs_q[2].wdata, 32'h1);
      chk("A_lock3_cycle", obs_q[9].cyc - s, 43);
      chk("A_sat_addr", obs_q[10].addr, 8'h20);
      chk("A_lock_reads", lock_reads, 3);

      // Lock stuck low: LOCK_POLLS reads then timeout. Abort with start in IDLE is dropped.
      start_pulse(28'h0123456, 2'd2, 1'b1);
      add_writes(28'h0123456, 2'd2, 7);
      add_reads(LP);
      s_end = r0 + (LP - 1) * (G + 2) + 2;
      release_start();
      wait_cyc(s_end);
      chk("B_done", o_done, 1);
      chk("B_err_to", o_err_timeout, 1);
      chk("B_locked", o_locked, 0);
      chk("B_all_seen", exp_q.size(), 0);
      chk("B_lock_reads", lock_reads, 4);
      chk("B_last_read_cycle", obs_q[10].cyc - s, 53);

      // Abort in the gap before the second poll: one ADPLL_EN=0 write, then finish.
      start_pulse(28'h0ABCDEF, 2'd0, 1'b0);
      add_writes(28'h0ABCDEF, 2'd0, 7);
      add_reads(1);
      exp_q.push_back('{r0 + 5, A_EN, 32'd0, 1'b1});
      s_end = r0 + 7;
      release_start();
      at_cycle(r0 + 4);
      i_abort = 1'b1;
      @(posedge clk);
      #1 i_abort = 1'b0;
      wait_cyc(s_end);
      chk("C_done", o_done, 1);
      chk("C_locked", o_locked, 0);
      chk("C_err_to", o_err_timeout, 0);
      chk("C_all_seen", exp_q.size(), 0);
      chk("C_abort_addr", obs_q[obs_q.size() - 1].addr, 8'h18);
      chk("C_abort_cycle", obs_q[obs_q.size() - 1].cyc - s, 28);
      chk("C_lock_reads", lock_reads, 1);

      // Silent slave: err_bus four cycles after the first valid, nothing further.
      slave_en = 1'b0;
      start_pulse(28'h0000001, 2'd3, 1'b0);
      add_writes(28'h0000001, 2'd3, 1);
      s_end = s + 5;
      release_start();
      wait_cyc(s + 4);
      chk("D_err_bus_early", o_err_bus, 0);
      wait_cyc(s + 5);
      chk("D_err_bus", o_err_bus, 1);
      chk("D_done", o_done, 1);
      wait_cyc(s + 15);
      chk("D_n_txn", obs_q.size(), 1);
      slave_en = 1'b1;

      // Reset during write 3, then a fresh start replays the list from SOFT_RST.
      start_pulse(28'h0000777, 2'd3, 1'b0);
      add_writes(28'h0000777, 2'd3, 3);
      s_end = s + 100000;
      release_start();
      at_cycle(s + 7);
      mon_on = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("E_rst_valid", o_valid, 0);
      chk("E_rst_busy", o_busy, 0);
      chk("E_rst_addr", o_address, 0);
      chk("E_rst_wdata", o_wdata, 0);
      chk("E_rst_done", o_done, 0);
      chk("E_n_txn", obs_q.size(), 3);
      chk("E_all_seen", exp_q.size(), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      lock_q = '{1'b1};
      start_pulse(28'h2620000, 2'd1, 1'b0);
      add_writes(28'h2620000, 2'd1, 7);
      add_reads(1);
      exp_q.push_back('{r0 + 2, A_SAT, 32'd0, 1'b0});
      s_end = r0 + 4;
      release_start();
      wait_cyc(s_end);
      chk("E2_done", o_done, 1);
      chk("E2_locked", o_locked, 1);
      chk("E2_all_seen", exp_q.size(), 0);
      chk("E2_first_cycle", obs_q[0].cyc - s, 1);
      chk("E2_first_addr", obs_q[0].addr, 8'h00);
      chk("E2_n_txn", obs_q.size(), 9);

      mon_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
